// File: rtl/crc_par_engine.sv
// Parallel-input CRC engine: P message bits per accepted beat, MSB-first LFSR.
// Optional final XOR with XOROUT is enabled by defining CRC_XOROUT_EN.
module crc_par_engine #(
    parameter int unsigned CRC_W  = 8,
    parameter logic [31:0] POLY   = 32'h07,
    parameter int unsigned P      = 3,
    parameter logic [31:0] INIT   = 32'h0,
    parameter logic [31:0] XOROUT = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [P-1:0]     in_data,
    input  logic             in_first,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             crc_valid,
    output logic [CRC_W-1:0] crc_out,
    output logic [15:0]      msg_beats,
    output logic             err
);

    if (CRC_W < 4 || CRC_W > 32 || P < 1 || P > CRC_W ||
        (POLY >> CRC_W) != 0 || (INIT >> CRC_W) != 0 || (XOROUT >> CRC_W) != 0) begin : g_bad_params
        $error("crc_par_engine: parameter out of range");
    end

    localparam logic [CRC_W-1:0] POLY_W = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] INIT_W = INIT[CRC_W-1:0];

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t           state, state_nxt;
    logic [CRC_W-1:0] crc_reg, crc_nxt;
    logic [15:0]      beat_cnt, cnt_nxt;
    logic             err_nxt;
    logic             load_result;
    logic             accept;
    logic [CRC_W-1:0] result;

    // P serial LFSR steps unrolled; in_data[P-1] enters the register first.
    function automatic logic [CRC_W-1:0] crc_advance(input logic [CRC_W-1:0] c,
                                                     input logic [P-1:0]     d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int unsigned i = 0; i < P; i++) begin
            fb = r[CRC_W-1] ^ d[P-1-i];
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY_W : '0);
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        crc_nxt     = crc_reg;
        cnt_nxt     = beat_cnt;
        err_nxt     = 1'b0;
        load_result = 1'b0;
        in_ready    = (state != HOLD);
        accept      = in_valid && in_ready;

        case (state)
            IDLE, RUN: begin
                if (accept) begin
                    if (in_first) begin
                        // A first beat always restarts; mid-message it also flags the abandoned one.
                        err_nxt     = (state == RUN);
                        crc_nxt     = crc_advance(INIT_W, in_data);
                        cnt_nxt     = 16'd1;
                        load_result = in_last;
                        state_nxt   = in_last ? HOLD : RUN;
                    end else if (state == IDLE) begin
                        err_nxt = 1'b1;
                    end else begin
                        crc_nxt     = crc_advance(crc_reg, in_data);
                        cnt_nxt     = (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;
                        load_result = in_last;
                        state_nxt   = in_last ? HOLD : RUN;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef CRC_XOROUT_EN
    localparam logic [CRC_W-1:0] XOROUT_W = XOROUT[CRC_W-1:0];
    assign result = crc_nxt ^ XOROUT_W;
`else
    assign result = crc_nxt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_reg   <= INIT_W;
            beat_cnt  <= '0;
            crc_out   <= '0;
            msg_beats <= '0;
            err       <= 1'b0;
        end else begin
            crc_reg  <= crc_nxt;
            beat_cnt <= cnt_nxt;
            err      <= err_nxt;
            if (load_result) begin
                crc_out   <= result;
                msg_beats <= cnt_nxt;
            end
        end
    end

    assign crc_valid = (state == HOLD);

endmodule

// File: tb/tb_crc_par_engine.sv
// Directed self-checking bench for crc_par_engine (defaults: CRC-8, poly 0x07, 3 bits/beat).
// Define CRC_XOROUT_EN for both bench and RTL to check the XOROUT = 0x55 build.
module tb_crc_par_engine;

`ifdef CRC_XOROUT_EN
    localparam logic [7:0] XO = 8'h55;
`else
    localparam logic [7:0] XO = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [2:0] in_data;
    logic       in_first;
    logic       in_last;
    logic       in_ready;
    logic       out_ready;
    logic       crc_valid;
    logic [7:0] crc_out;
    logic [15:0] msg_beats;
    logic       err;

    int         tests = 0;
    int         fails = 0;
    logic [71:0] msg;
    logic       err_first;
    logic       valid_before_last;
    logic [7:0] held_crc;

    crc_par_engine #(
        .CRC_W (8),
        .POLY  (32'h07),
        .P     (3),
        .INIT  (32'h0),
        .XOROUT(32'h55)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_first (in_first),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_ready(out_ready),
        .crc_valid(crc_valid),
        .crc_out  (crc_out),
        .msg_beats(msg_beats),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [2:0] d, input logic f, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_first = f;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends the first n beats of "123456789"; beat 23 carries in_last.
    task automatic send_msg(input int n);
        for (int i = 0; i < n; i++) begin
            if (i == 23) valid_before_last = crc_valid;
            beat(msg[71-3*i -: 3], i == 0, i == 23);
            if (i == 0) err_first = err;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        msg       = "123456789";
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 3'b000;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_crc_valid", crc_valid, 0);
        check("rst_crc_out", crc_out, 0);
        check("rst_msg_beats", msg_beats, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Check string, latency 1
        send_msg(24);
        check("str_err_first", err_first, 0);
        check("str_valid_before_last", valid_before_last, 0);
        check("str_valid", crc_valid, 1);
        check("str_crc", crc_out, 8'hF4 ^ XO);
        check("str_beats", msg_beats, 24);
        check("str_in_ready", in_ready, 0);

        // Back-pressure: a pending first+last beat must wait for the handshake
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; in_data = 3'b111;
        repeat (10) @(posedge clk);
        #1;
        check("hold_valid", crc_valid, 1);
        check("hold_in_ready", in_ready, 0);
        check("hold_crc", crc_out, 8'hF4 ^ XO);
        check("hold_beats", msg_beats, 24);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hs_valid_drop", crc_valid, 0);
        check("hs_in_ready", in_ready, 1);
        check("hs_crc_kept", crc_out, 8'hF4 ^ XO);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        check("pend_valid", crc_valid, 1);
        check("pend_crc_111", crc_out, 8'h15 ^ XO);
        check("pend_beats", msg_beats, 1);
        handshake();

        // 000 000 001 -> 0x07, then 9 zero bits -> 0x00
        beat(3'b000, 1'b1, 1'b0);
        beat(3'b000, 1'b0, 1'b0);
        beat(3'b001, 1'b0, 1'b1);
        check("m001_crc", crc_out, 8'h07 ^ XO);
        check("m001_beats", msg_beats, 3);
        handshake();
        check("m001_crc_after_hs", crc_out, 8'h07 ^ XO);
        beat(3'b000, 1'b1, 1'b0);
        beat(3'b000, 1'b0, 1'b0);
        beat(3'b000, 1'b0, 1'b1);
        check("zero_crc", crc_out, 8'h00 ^ XO);
        check("zero_beats", msg_beats, 3);
        handshake();

        // Beat without in_first in IDLE
        beat(3'b101, 1'b0, 1'b0);
        check("idle_err", err, 1);
        check("idle_no_valid", crc_valid, 0);
        check("idle_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        check("idle_err_clear", err, 0);
        check("idle_crc_kept", crc_out, 8'h00 ^ XO);
        beat(3'b001, 1'b1, 1'b1);
        check("single_crc", crc_out, 8'h07 ^ XO);
        check("single_beats", msg_beats, 1);
        handshake();

        // Restart mid-message
        beat(3'b111, 1'b1, 1'b0);
        beat(3'b010, 1'b0, 1'b0);
        check("pre_restart_err", err, 0);
        send_msg(24);
        check("restart_err", err_first, 1);
        check("restart_crc", crc_out, 8'hF4 ^ XO);
        check("restart_beats", msg_beats, 24);
        handshake();

        // Reset at beat 5 of 24
        send_msg(5);
        reset = 1'b1;
        #1;
        check("midrst_valid", crc_valid, 0);
        check("midrst_crc_out", crc_out, 0);
        check("midrst_beats", msg_beats, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_no_valid", crc_valid, 0);
        send_msg(24);
        check("postrst_crc", crc_out, 8'hF4 ^ XO);
        check("postrst_beats", msg_beats, 24);
        held_crc = crc_out;

        // Reset while holding a result
        reset = 1'b1;
        #1;
        check("holdrst_valid", crc_valid, 0);
        check("holdrst_in_ready", in_ready, 1);
        check("holdrst_crc_out", crc_out, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        beat(3'b111, 1'b1, 1'b1);
        check("final_crc", crc_out, 8'h15 ^ XO);
        check("final_differs", (crc_out != held_crc), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
